// File: rtl/relm_fp_normalize.sv
// rtl/relm_fp_normalize.sv - two-stage normalize/round/pack back end for the ReLM FP unit
// Stage 1 normalizes the raw mantissa; stage 2 rounds to nearest even and packs IEEE single.
module relm_fp_normalize #(
  parameter int WD = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] a_in,
  input  logic [WD-1:0] b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] q_out
);

  logic        w_en;

  logic [4:0]  w_lz;
  logic [31:0] w_shift;
  logic [9:0]  w_e;
  logic [9:0]  w_e1;
  logic [22:0] w_m;
  logic        w_g;
  logic        w_s;
  logic        w_unused;

  logic        r_s1_valid;
  logic        r_s1_sign;
  logic        r_s1_inf;
  logic        r_s1_zflag;
  logic        r_s1_exact0;
  logic [9:0]  r_s1_e1;
  logic [22:0] r_s1_m;
  logic        r_s1_g;
  logic        r_s1_s;

  logic        w_rnd;
  logic [23:0] w_sum;
  logic [9:0]  w_e2;
  logic [31:0] w_q;

  logic        r_out_valid;
  logic [31:0] r_q;

  // One global enable stalls both stages together while the output is held.
  assign w_en      = !r_out_valid | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign q_out     = r_q;

  assign w_unused = ^{b_in[20:0], w_shift[31:30]};

  always_comb begin
    w_lz = 5'd0;
    // Last hit wins, so the highest set bit decides the count.
    for (int i = 0; i < 31; i++) begin
      if (a_in[i]) w_lz = 5'(30 - i);
    end
    w_shift = a_in << w_lz;
    w_e     = {2'b00, b_in[30:23]};
    if (a_in[31]) begin
      w_e1 = w_e + 10'd1;
      w_m  = a_in[30:8];
      w_g  = a_in[7];
      w_s  = |a_in[6:0];
    end else begin
      w_e1 = w_e - {5'd0, w_lz};
      w_m  = w_shift[29:7];
      w_g  = w_shift[6];
      w_s  = |w_shift[5:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_inf    <= 1'b0;
      r_s1_zflag  <= 1'b0;
      r_s1_exact0 <= 1'b0;
      r_s1_e1     <= 10'd0;
      r_s1_m      <= 23'd0;
      r_s1_g      <= 1'b0;
      r_s1_s      <= 1'b0;
    end else if (w_en) begin
      r_s1_valid  <= in_valid;
      r_s1_sign   <= b_in[31];
      r_s1_inf    <= b_in[22];
      r_s1_zflag  <= b_in[21];
      r_s1_exact0 <= (a_in == 32'd0);
      r_s1_e1     <= w_e1;
      r_s1_m      <= w_m;
      r_s1_g      <= w_g;
      r_s1_s      <= w_s;
    end
  end

  always_comb begin
    w_rnd = r_s1_g & (r_s1_s | r_s1_m[0]);
    // A mantissa carry leaves the low 23 bits zero, so only the exponent needs bumping.
    w_sum = {1'b0, r_s1_m} + {23'd0, w_rnd};
    w_e2  = r_s1_e1 + {9'd0, w_sum[23]};
    w_q   = {r_s1_sign, w_e2[7:0], w_sum[22:0]};
    if (r_s1_inf && r_s1_zflag) begin
      w_q = {r_s1_sign, 8'hFF, 23'h400000};
    end else if (r_s1_inf) begin
      w_q = {r_s1_sign, 8'hFF, 23'd0};
    end else if (r_s1_zflag) begin
      w_q = {r_s1_sign, 31'd0};
    end else if (r_s1_exact0) begin
      w_q = 32'h00000000;
    end else if ($signed(w_e2) >= 10'sd255) begin
      w_q = {r_s1_sign, 8'hFF, 23'd0};
    end else if ($signed(w_e2) <= 10'sd0) begin
      w_q = {r_s1_sign, 31'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_q         <= 32'd0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      r_q         <= w_q;
    end
  end

endmodule

// File: tb/tb_relm_fp_normalize.sv
// tb/tb_relm_fp_normalize.sv - scoreboard bench for relm_fp_normalize
module tb_relm_fp_normalize;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q_out;

  int          checks;
  int          errors;
  int          n_pushed;
  int          n_popped;
  logic [31:0] exp_q[$];
  logic        hold_valid;
  logic [31:0] hold_q;
  int          stall_seen;

  relm_fp_normalize #(.WD(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_out     (q_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: consumes results on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (hold_valid) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_q", q_out, hold_q);
      end
      hold_valid = out_valid && !out_ready;
      hold_q     = q_out;
      if (out_valid && !out_ready) begin
        stall_seen++;
        check("in_ready_stall", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %08h expected none", q_out);
        end else begin
          check("result", q_out, exp_q.pop_front());
          n_popped++;
        end
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected in_ready=1");
    end else begin
      exp_q.push_back(exp);
      n_pushed++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_count", n_popped, n_pushed);
  endtask

  logic [31:0] va[12];
  logic [31:0] vb[12];
  logic [31:0] ve[12];

  initial begin
    checks = 0; errors = 0; n_pushed = 0; n_popped = 0;
    hold_valid = 1'b0; hold_q = 32'd0; stall_seen = 0;
    reset = 1'b1; in_valid = 1'b0; a_in = 32'd0; b_in = 32'd0; out_ready = 1'b1;

    va[0]  = 32'h80000000; vb[0]  = 32'h3F800000; ve[0]  = 32'h40000000;
    va[1]  = 32'h40000040; vb[1]  = 32'h3F800000; ve[1]  = 32'h3F800000;
    va[2]  = 32'h400000C0; vb[2]  = 32'h3F800000; ve[2]  = 32'h3F800002;
    va[3]  = 32'h400000FF; vb[3]  = 32'h3F800000; ve[3]  = 32'h3F800002;
    va[4]  = 32'h00400000; vb[4]  = 32'h3F800000; ve[4]  = 32'h3B800000;
    va[5]  = 32'h00000000; vb[5]  = 32'h3F800000; ve[5]  = 32'h00000000;
    va[6]  = 32'h80000000; vb[6]  = 32'h7F000000; ve[6]  = 32'h7F800000;
    va[7]  = 32'h20000000; vb[7]  = 32'h00800000; ve[7]  = 32'h00000000;
    va[8]  = 32'h80000000; vb[8]  = 32'h80400000; ve[8]  = 32'hFF800000;
    va[9]  = 32'h80000000; vb[9]  = 32'h00600000; ve[9]  = 32'h7FC00000;
    va[10] = 32'h80000000; vb[10] = 32'h80200000; ve[10] = 32'h80000000;
    va[11] = 32'h7FFFFFC0; vb[11] = 32'h3F800000; ve[11] = 32'h40000000;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_q_out", q_out, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) send(va[i], vb[i], ve[i]);
    drain();

    // Stream of four with the consumer stalled for three cycles.
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 4; i++) send(va[i + 1], vb[i + 1], ve[i + 1]);
    drain();
    checks++;
    if (stall_seen == 0) begin
      errors++;
      $display("FAIL stall_observed: got 0 stalled cycles expected at least 1");
    end

    // Reset in the middle of a stream discards everything in flight.
    for (int i = 0; i < 3; i++) send(va[i], vb[i], ve[i]);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    n_popped = n_pushed;
    @(negedge clk);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_q_out", q_out, 32'd0);
    repeat (4) @(negedge clk);
    check("post_reset_idle", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    send(va[6], vb[6], ve[6]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
